enm_array: RTL and testbench

Parametrised enemy-formation controller: drives position registers for N_ENM enemies from their hit points, one update per clk_10ms edge. It supersedes the fixed four-enemy mover. Movement mode, spawn placement and zigzag direction are per-enemy parameters. It adds wave tracking: all-dead detection, a timed respawn pulse and a wave counter. It sits between the hit/HP logic and the sprite renderer.

---
 rtl/enm_array.sv | 110 +++++++++++
 tb/tb_enm_array.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/enm_array.sv
// enm_array: parametrised enemy-formation mover with wave tracking and timed respawn
module enm_array #(
  parameter int N_ENM = 4,
  parameter int HP_W = 7,
  parameter int POS_W = 10,
  parameter int HP_HI = 80,
  parameter int HP_LO = 40,
  parameter int X_MIN = 184,
  parameter int X_MID = 344,
  parameter int X_MAX = 504,
  parameter int X_SPAWN0 = 248,
  parameter int X_STEP = 64,
  parameter int Y_START = 40,
  parameter int Y_HOLD_R = 200,
  parameter int Y_HOLD_L = 150,
  parameter int Y_ZZ = 271,
  parameter logic [N_ENM-1:0] DIR_MASK = 4'b0110,
  parameter int RESPAWN_TICKS = 100
) (
  input  logic                     clk_10ms,
  input  logic                     switch,
  input  logic [N_ENM*HP_W-1:0]    enmhp,
  output logic [N_ENM*POS_W-1:0]   enmx,
  output logic [N_ENM*POS_W-1:0]   enmy,
  output logic [N_ENM-1:0]         alive,
  output logic                     wave_clr,
  output logic                     enmrst,
  output logic [7:0]               wave_cnt
);
  localparam int CW = $clog2(RESPAWN_TICKS) + 1;
  typedef logic [POS_W-1:0] pos_t;
  typedef logic [HP_W-1:0] hp_t;
  localparam pos_t ONE = pos_t'(1);
  localparam pos_t XMIN = pos_t'(X_MIN);
  localparam pos_t XMID = pos_t'(X_MID);
  localparam pos_t XMAX = pos_t'(X_MAX);
  localparam pos_t YST = pos_t'(Y_START);
  localparam pos_t YHR = pos_t'(Y_HOLD_R);
  localparam pos_t YHL = pos_t'(Y_HOLD_L);
  localparam pos_t YZZ = pos_t'(Y_ZZ);
  localparam pos_t ZR_A = pos_t'(Y_ZZ - X_MIN);
  localparam pos_t ZR_B = pos_t'(Y_ZZ + X_MAX);
  localparam pos_t ZL_A = pos_t'(X_MAX - Y_ZZ);
  localparam pos_t ZL_B = pos_t'(Y_ZZ + X_MIN);
  localparam hp_t HI = hp_t'(HP_HI);
  localparam hp_t LO = hp_t'(HP_LO);
  localparam logic [CW-1:0] CMAX = CW'(RESPAWN_TICKS - 1);
  logic [N_ENM-1:0][HP_W-1:0] hp;
  logic [N_ENM-1:0][POS_W-1:0] x_q, y_q, x_d, y_d, x_sp;
  logic [N_ENM-1:0] live;
  logic all_dead, all_dead_d, respawn;
  logic [CW-1:0] cnt;
  assign hp = enmhp;
  assign enmx = x_q;
  assign enmy = y_q;
  // per-enemy next position from the current hp-selected mode; zigzag y uses the pre-update x
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    x_sp = '0;
    live = '0;
    for (int i = 0; i < N_ENM; i++) begin
      x_sp[i] = pos_t'(X_SPAWN0 + i * X_STEP);
      live[i] = hp[i] != '0;
      if (hp[i] > HI)
        y_d[i] = (y_q[i] < (DIR_MASK[i] ? YHL : YHR)) ? y_q[i] + ONE : (DIR_MASK[i] ? YHL : YHR);
      else if (hp[i] > LO)
        x_d[i] = (x_q[i] < XMAX) ? x_q[i] + ONE : XMIN;
      else if (hp[i] == '0)
        x_d[i] = '0;
      else if (!DIR_MASK[i]) begin
        x_d[i] = (x_q[i] < XMAX) ? x_q[i] + ONE : XMIN;
        y_d[i] = (x_q[i] < XMID) ? x_q[i] + ZR_A : (x_q[i] < XMAX) ? ZR_B - x_q[i] : YZZ;
      end else begin
        x_d[i] = (x_q[i] > XMIN) ? x_q[i] - ONE : XMAX;
        y_d[i] = (x_q[i] > XMID) ? x_q[i] - ZL_A : (x_q[i] > XMIN) ? ZL_B - x_q[i] : YZZ;
      end
    end
    all_dead = ~|live;
    respawn = all_dead && (cnt == CMAX);
  end
  // state update: switch reset beats respawn reload, which beats the mode update
  always_ff @(posedge clk_10ms) begin
    if (switch) begin
      x_q <= x_sp;
      y_q <= {N_ENM{YST}};
      alive <= '0;
      wave_clr <= 1'b0;
      enmrst <= 1'b0;
      wave_cnt <= '0;
      cnt <= '0;
      all_dead_d <= 1'b0;
    end else begin
      alive <= live;
      wave_clr <= all_dead & ~all_dead_d;
      all_dead_d <= all_dead;
      enmrst <= respawn;
      if (respawn) begin
        x_q <= x_sp;
        y_q <= {N_ENM{YST}};
        cnt <= '0;
        wave_cnt <= wave_cnt + 8'd1;
      end else begin
        x_q <= x_d;
        y_q <= y_d;
        cnt <= all_dead ? cnt + CW'(1) : '0;
      end
    end
  end
endmodule

// File: tb/tb_enm_array.sv
// tb_enm_array: directed scoreboard bench for enm_array with an 8-tick respawn
module tb_enm_array;
  logic clk_10ms = 1'b0;
  logic switch = 1'b1;
  logic [27:0] enmhp = '0;
  logic [39:0] enmx, enmy;
  logic [3:0] alive;
  logic wave_clr, enmrst;
  logic [7:0] wave_cnt;
  typedef struct {
    bit chk;
    string nm;
    logic [39:0] x;
    logic [39:0] y;
    logic [3:0] al;
    logic wc;
    logic er;
    logic [7:0] wn;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  enm_array #(.RESPAWN_TICKS(8)) dut (
    .clk_10ms(clk_10ms),
    .switch(switch),
    .enmhp(enmhp),
    .enmx(enmx),
    .enmy(enmy),
    .alive(alive),
    .wave_clr(wave_clr),
    .enmrst(enmrst),
    .wave_cnt(wave_cnt)
  );
  always #5 clk_10ms = ~clk_10ms;
  function automatic logic [39:0] p4(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction
  function automatic logic [27:0] h4(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction
  task automatic cyc(input logic [27:0] hp, input logic sw, input bit chk, input string nm,
                     input logic [39:0] ex, input logic [39:0] ey, input logic [3:0] al,
                     input logic wc, input logic er, input logic [7:0] wn);
    exp_t e;
    enmhp = hp;
    switch = sw;
    e.chk = chk;
    e.nm = nm;
    e.x = ex;
    e.y = ey;
    e.al = al;
    e.wc = wc;
    e.er = er;
    e.wn = wn;
    q.push_back(e);
    @(posedge clk_10ms);
    #1;
  endtask
  task automatic run(input int n, input logic [27:0] hp);
    repeat (n) cyc(hp, 1'b0, 1'b0, "", '0, '0, '0, 1'b0, 1'b0, '0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_10ms);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          tests++;
          if (enmx !== e.x) begin
            fails++;
            $display("FAIL %s enmx got %h expected %h", e.nm, enmx, e.x);
          end
          tests++;
          if (enmy !== e.y) begin
            fails++;
            $display("FAIL %s enmy got %h expected %h", e.nm, enmy, e.y);
          end
          tests++;
          if ({alive, wave_clr, enmrst, wave_cnt} !== {e.al, e.wc, e.er, e.wn}) begin
            fails++;
            $display("FAIL %s flags alive/wave_clr/enmrst/wave_cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                     e.nm, alive, wave_clr, enmrst, wave_cnt, e.al, e.wc, e.er, e.wn);
          end
        end
      end
    end
  end
  initial begin
    logic [39:0] sx, y40, yh, yd;
    logic [27:0] a, b, c, dead, z;
    sx = p4(248, 312, 376, 440);
    y40 = p4(40, 40, 40, 40);
    yh = p4(200, 150, 150, 200);
    yd = p4(200, 270, 150, 200);
    a = h4(100, 100, 100, 100);
    b = h4(60, 100, 100, 100);
    c = h4(30, 100, 100, 100);
    dead = h4(0, 0, 0, 0);
    cyc(dead, 1'b1, 1'b0, "", '0, '0, '0, 1'b0, 1'b0, '0);
    cyc(a, 1'b1, 1'b1, "reset", sx, y40, 4'h0, 1'b0, 1'b0, 8'd0);
    cyc(a, 1'b0, 1'b1, "enter1", sx, p4(41, 41, 41, 41), 4'hF, 1'b0, 1'b0, 8'd0);
    run(108, a);
    cyc(a, 1'b0, 1'b1, "enter110", sx, p4(150, 150, 150, 150), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(a, 1'b0, 1'b1, "enter111", sx, p4(151, 150, 150, 151), 4'hF, 1'b0, 1'b0, 8'd0);
    run(48, a);
    cyc(a, 1'b0, 1'b1, "enter160", sx, yh, 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(a, 1'b0, 1'b1, "enter161", sx, yh, 4'hF, 1'b0, 1'b0, 8'd0);
    run(255, b);
    cyc(b, 1'b0, 1'b1, "sweep504", p4(504, 312, 376, 440), yh, 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(b, 1'b0, 1'b1, "sweepwrap", p4(184, 312, 376, 440), yh, 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(c, 1'b0, 1'b1, "zz1", p4(185, 312, 376, 440), p4(271, 150, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    run(158, c);
    cyc(c, 1'b0, 1'b1, "zz344", p4(344, 312, 376, 440), p4(430, 150, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(c, 1'b0, 1'b1, "zz345", p4(345, 312, 376, 440), p4(431, 150, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    run(158, c);
    cyc(c, 1'b0, 1'b1, "zz504", p4(504, 312, 376, 440), p4(272, 150, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(c, 1'b0, 1'b1, "zzwrap", p4(184, 312, 376, 440), p4(271, 150, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(h4(100, 0, 100, 100), 1'b0, 1'b1, "kill1", p4(184, 0, 376, 440), yh, 4'b1101, 1'b0, 1'b0, 8'd0);
    cyc(h4(100, 30, 100, 100), 1'b0, 1'b1, "left_jump", p4(184, 504, 376, 440), p4(200, 271, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(h4(100, 30, 100, 100), 1'b0, 1'b1, "left_step", p4(184, 503, 376, 440), p4(200, 271, 150, 200), 4'hF, 1'b0, 1'b0, 8'd0);
    cyc(h4(100, 30, 100, 100), 1'b0, 1'b1, "left_step2", p4(184, 502, 376, 440), yd, 4'hF, 1'b0, 1'b0, 8'd0);
    z = '0;
    cyc(dead, 1'b0, 1'b1, "dead1", 40'd0, yd, 4'h0, 1'b1, 1'b0, 8'd0);
    cyc(dead, 1'b0, 1'b1, "dead2", 40'd0, yd, 4'h0, 1'b0, 1'b0, 8'd0);
    run(4, dead);
    cyc(dead, 1'b0, 1'b1, "dead7", 40'd0, yd, 4'h0, 1'b0, 1'b0, 8'd0);
    cyc(dead, 1'b0, 1'b1, "respawn1", sx, y40, 4'h0, 1'b0, 1'b1, 8'd1);
    cyc(dead, 1'b0, 1'b1, "after_rsp", 40'd0, y40, 4'h0, 1'b0, 1'b0, 8'd1);
    run(5, dead);
    cyc(dead, 1'b0, 1'b1, "dead15", 40'd0, y40, 4'h0, 1'b0, 1'b0, 8'd1);
    cyc(dead, 1'b0, 1'b1, "respawn2", sx, y40, 4'h0, 1'b0, 1'b1, 8'd2);
    cyc(dead, 1'b0, 1'b1, "dead17", 40'd0, y40, 4'h0, 1'b0, 1'b0, 8'd2);
    run(4, dead);
    cyc(h4(0, 0, 50, 0), 1'b0, 1'b1, "revive2", p4(0, 0, 1, 0), y40, 4'b0100, 1'b0, 1'b0, 8'd2);
    cyc(dead, 1'b0, 1'b1, "rekill", 40'd0, y40, 4'h0, 1'b1, 1'b0, 8'd2);
    run(1, dead);
    cyc(dead, 1'b0, 1'b1, "k3", 40'd0, y40, 4'h0, 1'b0, 1'b0, 8'd2);
    run(3, dead);
    cyc(dead, 1'b0, 1'b1, "k7", 40'd0, y40, 4'h0, 1'b0, 1'b0, 8'd2);
    cyc(dead, 1'b0, 1'b1, "respawn3", sx, y40, 4'h0, 1'b0, 1'b1, 8'd3);
    cyc(c, 1'b0, 1'b1, "zzsp1", p4(249, 312, 376, 440), p4(335, 41, 41, 41), 4'hF, 1'b0, 1'b0, 8'd3);
    cyc(c, 1'b0, 1'b1, "zzsp2", p4(250, 312, 376, 440), p4(336, 42, 42, 42), 4'hF, 1'b0, 1'b0, 8'd3);
    cyc(c, 1'b1, 1'b1, "rst_zz", sx, y40, 4'h0, 1'b0, 1'b0, 8'd0);
    run(5, dead);
    cyc(dead, 1'b1, 1'b1, "rst_cnt", sx, y40, 4'h0, 1'b0, 1'b0, 8'd0);
    repeat (8) cyc(dead, 1'b1, 1'b0, "", '0, '0, '0, 1'b0, 1'b0, '0);
    cyc(dead, 1'b1, 1'b1, "rst_hold", sx, y40, 4'h0, 1'b0, 1'b0, 8'd0);
    cyc(dead, 1'b0, 1'b1, "post_rst", z[27:0] == '0 ? 40'd0 : 40'd0, y40, 4'h0, 1'b1, 1'b0, 8'd0);
    repeat (2) @(negedge clk_10ms);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
